dino_jump_ctrl: RTL

Jump sequencer for the dinosaur sprite. Parses raw PS/2 scancode bytes from PS2_Controller into jump/duck key state. Runs a tick-paced fixed-point ballistic FSM that produces the dino's height above ground for the renderer and collision logic. Sits between PS2_Controller and the game/VGA datapath.

---
 rtl/dino_jump_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl
// ----------------------------------------------------------------------------
// Jump sequencer for the dinosaur sprite. It decodes raw PS/2 scancode bytes
// into jump/duck key state. A tick-paced ballistic FSM then produces the
// dino's height above ground for the renderer and the collision logic.
//
// Optional feature macro: SHORT_HOP_EN
//   defined   : while rising, releasing the jump key caps the upward velocity
//               at CUT_VEL straight away, giving a short hop.
//   undefined : key release has no effect, so every jump reaches full height.
//
// Ports
//   CLOCK_50         in   system clock
//   reset            in   asynchronous, active-high reset
//   ps2_key_data     in   [7:0] scancode byte from PS2_Controller
//   ps2_key_pressed  in   one-cycle strobe qualifying ps2_key_data
//   freeze           in   1 = physics and tick counter hold (keys still tracked)
//   height           out  [9:0] unsigned height above ground
//   velocity         out  [7:0] signed vertical velocity, units/tick
//   state            out  [1:0] 0 IDLE, 1 RISE, 2 FALL, 3 LAND (debug-visible FSM)
//   airborne         out  state is RISE or FALL
//   ducking          out  duck key held while IDLE
//   landed           out  one-cycle pulse on entry to LAND
//   jump_held        out  jump key currently down
//   duck_held        out  duck key currently down
//
// Handshake: the input side has no back-pressure. A byte is consumed on every
// cycle where ps2_key_pressed is 1, and ignored otherwise.
// ----------------------------------------------------------------------------
module dino_jump_ctrl #(
  parameter int             TICK_DIV   = 1562500,
  parameter logic [7:0]     JUMP_CODE  = 8'h1C,
  parameter logic [7:0]     DUCK_CODE  = 8'h1B,
  parameter int             JUMP_VEL   = 40,
  parameter int             GRAVITY    = 2,
  parameter int             MAX_HEIGHT = 1000,
  parameter int             CUT_VEL    = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  input  logic       freeze,
  output logic [9:0] height,
  output logic [7:0] velocity,
  output logic [1:0] state,
  output logic       airborne,
  output logic       ducking,
  output logic       landed,
  output logic       jump_held,
  output logic       duck_held
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2,
    ST_LAND = 2'd3
  } state_t;

  localparam int                  CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(TICK_DIV - 1);
  localparam logic signed [11:0]  GRAV_S     = 12'(GRAVITY);
  localparam logic signed [11:0]  MAX_S      = 12'(MAX_HEIGHT);
  localparam logic signed [11:0]  VEL_MIN    = -12'sd128;
  localparam logic [9:0]          MAX_H10    = 10'(MAX_HEIGHT);
  localparam logic signed [7:0]   JUMP_V8    = 8'(JUMP_VEL);
`ifdef SHORT_HOP_EN
  localparam logic signed [7:0]   CUT_S      = 8'(CUT_VEL);
`endif

  // Elaboration-time guard: out-of-range parameters would break the
  // no-wrap guarantees of the arithmetic below.
  if (JUMP_VEL < 1 || JUMP_VEL > 127 || GRAVITY < 1 || MAX_HEIGHT < 0 ||
      MAX_HEIGHT > 1023 || CUT_VEL < 0 || CUT_VEL > 127 || TICK_DIV < 1)
  begin : g_param_check
    $error("dino_jump_ctrl: parameter out of range");
  end

  // Registered state
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ext_q, ext_d;
  logic               brk_q, brk_d;
  logic               jump_held_q, jump_held_d;
  logic               duck_held_q, duck_held_d;
  logic               jump_req_q, jump_req_d;
  state_t             state_q, state_d;
  logic [9:0]         height_q, height_d;
  logic signed [7:0]  vel_q, vel_d;
  logic               landed_q, landed_d;

  // Combinational helpers
  logic               tick;
  logic               jump_make;
  logic               req_consume;
  logic signed [11:0] height_ext, vel_ext, sum, nv_wide;
  logic signed [7:0]  vel_next;

  // Physics tick divider. It holds completely while frozen, so a freeze
  // resumes mid-period exactly where it stopped.
  always_comb begin
    tick  = !freeze && (cnt_q == '0);
    cnt_d = cnt_q;
    if (!freeze) begin
      cnt_d = (cnt_q == '0) ? CNT_RELOAD : cnt_q - CNT_W'(1);
    end
  end

  // Scancode parser. E0/F0 are prefixes. Any other byte ends the sequence.
  // Extended-prefixed keys are ignored, so E0 1C never counts as jump.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    jump_held_d = jump_held_q;
    duck_held_d = duck_held_q;
    jump_make   = 1'b0;
    if (ps2_key_pressed) begin
      if (ps2_key_data == 8'hE0) begin
        ext_d = 1'b1;
      end else if (ps2_key_data == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (!ext_q) begin
          if (ps2_key_data == JUMP_CODE) begin
            jump_held_d = !brk_q;
            jump_make   = !brk_q;
          end
          if (ps2_key_data == DUCK_CODE) begin
            duck_held_d = !brk_q;
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Ballistic arithmetic, done at 12 bits signed so that nothing wraps
  always_comb begin
    height_ext = {2'b00, height_q};
    vel_ext    = {{4{vel_q[7]}}, vel_q};
    sum        = height_ext + vel_ext;
    nv_wide    = vel_ext - GRAV_S;
    vel_next   = (nv_wide < VEL_MIN) ? 8'sh80 : nv_wide[7:0];
  end

  // FSM next-state and physics update, tick-gated
  always_comb begin
    state_d     = state_q;
    height_d    = height_q;
    vel_d       = vel_q;
    landed_d    = 1'b0;
    req_consume = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (jump_req_q) begin
            req_consume = 1'b1;
            if (!duck_held_q) begin
              vel_d   = JUMP_V8;
              state_d = ST_RISE;
            end
          end
        end
        ST_RISE, ST_FALL: begin
          if (sum <= 12'sd0) begin
            height_d = 10'd0;
            vel_d    = 8'sd0;
            state_d  = ST_LAND;
            landed_d = 1'b1;
          end else if (sum > MAX_S) begin
            // Hitting the ceiling kills the upward motion outright
            height_d = MAX_H10;
            vel_d    = 8'sd0;
            state_d  = ST_FALL;
          end else begin
            height_d = sum[9:0];
            vel_d    = vel_next;
            state_d  = (vel_next > 8'sd0) ? ST_RISE : ST_FALL;
          end
        end
        ST_LAND: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

`ifdef SHORT_HOP_EN
    // Release cut. It reacts on the same cycle the key goes up and is not
    // tick-gated. It is applied after the tick update, so it also caps nv.
    if (!freeze && state_q == ST_RISE && jump_held_q && !jump_held_d &&
        vel_d > CUT_S) begin
      vel_d = CUT_S;
    end
`endif

    // A fresh make (not a typematic repeat) is accepted only on the ground.
    // If a new request and a consumption coincide, the new request wins.
    jump_req_d = (jump_req_q && !req_consume) ||
                 (jump_make && !jump_held_q &&
                  (state_q == ST_IDLE || state_q == ST_LAND));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q       <= CNT_RELOAD;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      jump_held_q <= 1'b0;
      duck_held_q <= 1'b0;
      jump_req_q  <= 1'b0;
      state_q     <= ST_IDLE;
      height_q    <= 10'd0;
      vel_q       <= 8'sd0;
      landed_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      jump_held_q <= jump_held_d;
      duck_held_q <= duck_held_d;
      jump_req_q  <= jump_req_d;
      state_q     <= state_d;
      height_q    <= height_d;
      vel_q       <= vel_d;
      landed_q    <= landed_d;
    end
  end

  assign height    = height_q;
  assign velocity  = vel_q;
  assign state     = state_q;
  assign airborne  = (state_q == ST_RISE) || (state_q == ST_FALL);
  assign ducking   = duck_held_q && (state_q == ST_IDLE);
  assign landed    = landed_q;
  assign jump_held = jump_held_q;
  assign duck_held = duck_held_q;

endmodule
